skolem_bvshl_checker: RTL and testbench

Sequential exhaustive checker placed directly downstream of a 4-bit bvule/bvshl Skolem-function block. It drives every input vector into the combinational Skolem module and reads back its candidate witness. For each vector it brute-forces whether any witness exists, then flags every vector where a witness exists but the candidate fails the constraint. It reports pass/fail, a saturating failure count and the first failing vector for regression sign-off of generated Skolem netlists.

---
 rtl/skolem_bvshl_checker.sv | 158 +++++++++++++++
 tb/tb_skolem_bvshl_checker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skolem_bvshl_checker.sv
// Exhaustive checker for a W-bit bvule/bvshl Skolem block: sweeps every (s,t) vector,
// brute-forces witness existence and flags vectors whose candidate x breaks the constraint.
module skolem_bvshl_checker #(
    parameter int W          = 4,
    parameter int SETTLE_CYC = 1,
    parameter int OP_SEL     = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [2*W-1:0] sk_in,
    input  logic [W-1:0]   sk_out,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   fail_count,
    output logic [2*W-1:0] first_fail_vec,
    output logic           first_fail_valid,
    output logic [2:0]     dbg_state
);

    // Handshake: start is sampled only in IDLE (ignored while busy, DONE included); done
    // pulses for one cycle at run end; pass/fail_count/first_fail_* hold until the next
    // accepted start.

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SEARCH = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [2*W-1:0] r_vec;
    logic [SCW-1:0] r_settle_cnt;
    logic [W-1:0]   r_x_idx;
    logic           r_exists;
    logic           r_busy;
    logic           r_pass;
    logic [2*W:0]   r_fail_count;
    logic [2*W-1:0] r_ff_vec;
    logic           r_ff_valid;

    logic [W-1:0]   w_s;
    logic [W-1:0]   w_t;
    logic           w_settle_last;
    logic           w_x_last;
    logic           w_vec_last;
    logic           w_hold_x;
    logic           w_hold_cand;
    logic           w_fail;

    // Shift amounts of W or more shift everything out, giving 0.
    function automatic logic holds(input logic [W-1:0] x, input logic [W-1:0] s,
                                   input logic [W-1:0] t);
        logic [W-1:0] r;
        r = (OP_SEL == 0) ? (x << s) : (s << x);
        return r <= t;
    endfunction

    assign w_s           = r_vec[W-1:0];
    assign w_t           = r_vec[2*W-1:W];
    assign w_settle_last = (r_settle_cnt == SCW'(SETTLE_CYC - 1));
    assign w_x_last      = (r_x_idx == '1);
    assign w_vec_last    = (r_vec == '1);
    assign w_hold_x      = holds(r_x_idx, w_s, w_t);
    assign w_hold_cand   = holds(sk_out, w_s, w_t);
    assign w_fail        = r_exists & ~w_hold_cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SETTLE;
            ST_SETTLE: if (w_settle_last) w_next = ST_SEARCH;
            ST_SEARCH: if (w_x_last) w_next = ST_CHECK;
            ST_CHECK:  w_next = w_vec_last ? ST_DONE : ST_SETTLE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_x_idx      <= '0;
            r_exists     <= 1'b0;
            r_busy       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_count <= '0;
            r_ff_vec     <= '0;
            r_ff_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vec        <= '0;
                        r_settle_cnt <= '0;
                        r_fail_count <= '0;
                        r_ff_valid   <= 1'b0;
                        r_pass       <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_settle_last) begin
                        r_x_idx  <= '0;
                        r_exists <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SCW'(1);
                    end
                end
                ST_SEARCH: begin
                    r_exists <= r_exists | w_hold_x;
                    r_x_idx  <= r_x_idx + W'(1);
                end
                ST_CHECK: begin
                    if (w_fail) begin
                        if (r_fail_count != '1) r_fail_count <= r_fail_count + (2*W+1)'(1);
                        if (!r_ff_valid) begin
                            r_ff_vec   <= r_vec;
                            r_ff_valid <= 1'b1;
                        end
                    end
                    // sk_in only moves on the edge that re-enters SETTLE.
                    if (!w_vec_last) begin
                        r_vec        <= r_vec + (2*W)'(1);
                        r_settle_cnt <= '0;
                    end
                end
                ST_DONE: begin
                    r_pass <= (r_fail_count == '0);
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sk_in            = r_vec;
    assign busy             = r_busy;
    assign done             = (r_state == ST_DONE);
    assign pass             = r_pass;
    assign fail_count       = r_fail_count;
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_valid;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_skolem_bvshl_checker.sv
// Bench for skolem_bvshl_checker: three instances (OP_SEL 0, OP_SEL 1, SETTLE_CYC 3) driven
// with ideal or stub Skolem models; run results are checked by per-instance scoreboards.
module tb_skolem_bvshl_checker;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SEARCH = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  // Latency counts the cycle start is presented in plus every edge up to done.
  localparam int LAT1 = 1 + 256 * 18;
  localparam int LAT3 = 1 + 256 * 20;
  localparam int TMO  = 6000;

  typedef struct packed {
    logic [15:0] lat;
    logic        pass;
    logic [8:0]  fc;
    logic [7:0]  ffv;
    logic        ffval;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic start_0 = 1'b0, start_1 = 1'b0, start_3 = 1'b0;
  logic [7:0] sk_in_0, sk_in_1, sk_in_3;
  logic [3:0] sk_out_0, sk_out_1, sk_out_3;
  logic busy_0, busy_1, busy_3, done_0, done_1, done_3, pass_0, pass_1, pass_3;
  logic [8:0] fc_0, fc_1, fc_3;
  logic [7:0] ffv_0, ffv_1, ffv_3;
  logic ffval_0, ffval_1, ffval_3;
  logic [2:0] st_0, st_1, st_3;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t exp_q3[$];
  int start_cyc0 = 0, start_cyc1 = 0, start_cyc3 = 0;
  int mode0 = 0;  // 0 ideal, 1 stub 4'hF, 2 stub 4'h0

  // Ideal Skolem block: minimal witness, 0 when none exists.
  function automatic logic [3:0] ideal(input logic [7:0] v, input int op);
    logic [3:0] s, t, r;
    s = v[3:0];
    t = v[7:4];
    for (int x = 0; x < 16; x++) begin
      r = (op == 0) ? (4'(x) << s) : (s << 4'(x));
      if (r <= t) return 4'(x);
    end
    return 4'h0;
  endfunction

  function automatic exp_t mk(input int lat, input logic p, input int fc, input int ffv,
                              input logic ffval);
    exp_t e;
    e.lat = 16'(lat); e.pass = p; e.fc = 9'(fc); e.ffv = 8'(ffv); e.ffval = ffval;
    return e;
  endfunction

  always_comb begin
    sk_out_0 = ideal(sk_in_0, 0);
    if (mode0 == 1) sk_out_0 = 4'hF;
    else if (mode0 == 2) sk_out_0 = 4'h0;
  end
  assign sk_out_1 = 4'h0;
  always_comb sk_out_3 = ideal(sk_in_3, 0);

  skolem_bvshl_checker #(.W(4), .SETTLE_CYC(1), .OP_SEL(0)) u0 (
    .clk(clk), .rst(rst), .start(start_0), .sk_in(sk_in_0), .sk_out(sk_out_0),
    .busy(busy_0), .done(done_0), .pass(pass_0), .fail_count(fc_0),
    .first_fail_vec(ffv_0), .first_fail_valid(ffval_0), .dbg_state(st_0));
  skolem_bvshl_checker #(.W(4), .SETTLE_CYC(1), .OP_SEL(1)) u1 (
    .clk(clk), .rst(rst), .start(start_1), .sk_in(sk_in_1), .sk_out(sk_out_1),
    .busy(busy_1), .done(done_1), .pass(pass_1), .fail_count(fc_1),
    .first_fail_vec(ffv_1), .first_fail_valid(ffval_1), .dbg_state(st_1));
  skolem_bvshl_checker #(.W(4), .SETTLE_CYC(3), .OP_SEL(0)) u3 (
    .clk(clk), .rst(rst), .start(start_3), .sk_in(sk_in_3), .sk_out(sk_out_3),
    .busy(busy_3), .done(done_3), .pass(pass_3), .fail_count(fc_3),
    .first_fail_vec(ffv_3), .first_fail_valid(ffval_3), .dbg_state(st_3));

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  task automatic judge(input string tag, input exp_t e, input int lat, input logic [8:0] fc,
                       input logic [7:0] ffv, input logic ffval);
    chk({tag, " done latency"}, lat, e.lat);
    chk({tag, " fail_count"}, fc, e.fc);
    chk({tag, " first_fail_valid"}, ffval, e.ffval);
    if (e.ffval) chk({tag, " first_fail_vec"}, ffv, e.ffv);
  endtask

  task automatic after_done(input string tag, input logic p, input logic b, input logic d,
                            input logic exp_p);
    chk({tag, " pass"}, p, exp_p);
    chk({tag, " busy after done"}, b, 1'b0);
    chk({tag, " done one cycle"}, d, 1'b0);
  endtask

  // ---------------- monitors ----------------
  initial begin : mon0
    exp_t e;
    logic pend, exp_p;
    pend = 1'b0; exp_p = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin after_done("u0", pass_0, busy_0, done_0, exp_p); pend = 1'b0; end
      if (done_0) begin
        if (exp_q0.size() == 0) fail_now("u0 unexpected done");
        else begin
          e = exp_q0.pop_front();
          judge("u0", e, cyc - start_cyc0, fc_0, ffv_0, ffval_0);
          pend = 1'b1; exp_p = e.pass;
        end
      end
    end
  end

  initial begin : mon1
    exp_t e;
    logic pend, exp_p;
    pend = 1'b0; exp_p = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin after_done("u1", pass_1, busy_1, done_1, exp_p); pend = 1'b0; end
      if (done_1) begin
        if (exp_q1.size() == 0) fail_now("u1 unexpected done");
        else begin
          e = exp_q1.pop_front();
          judge("u1", e, cyc - start_cyc1, fc_1, ffv_1, ffval_1);
          pend = 1'b1; exp_p = e.pass;
        end
      end
    end
  end

  initial begin : mon3
    exp_t e;
    logic pend, exp_p;
    pend = 1'b0; exp_p = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin after_done("u3", pass_3, busy_3, done_3, exp_p); pend = 1'b0; end
      if (done_3) begin
        if (exp_q3.size() == 0) fail_now("u3 unexpected done");
        else begin
          e = exp_q3.pop_front();
          judge("u3", e, cyc - start_cyc3, fc_3, ffv_3, ffval_3);
          pend = 1'b1; exp_p = e.pass;
        end
      end
    end
  end

  // u3 sk_in must step 0,1,2,... on SETTLE entry and stay put until the next entry.
  int viol3 = 0, entries3 = 0;
  initial begin : skin_mon3
    logic [7:0] exp_vec, held;
    logic [2:0] prev;
    exp_vec = 8'h00; held = 8'h00; prev = ST_IDLE;
    forever begin
      @(negedge clk);
      if (st_3 == ST_SETTLE && prev != ST_SETTLE) begin
        if (sk_in_3 !== exp_vec) viol3++;
        exp_vec = exp_vec + 8'h01;
        held = sk_in_3;
        entries3++;
      end else if ((st_3 == ST_SETTLE || st_3 == ST_SEARCH || st_3 == ST_CHECK)
                   && sk_in_3 !== held) begin
        viol3++;
      end
      prev = st_3;
    end
  end

  // ---------------- drivers ----------------
  task automatic start0(input int mode, input exp_t e);
    @(negedge clk);
    mode0 = mode;
    start_0 = 1'b1;
    start_cyc0 = cyc;
    exp_q0.push_back(e);
    @(negedge clk);
    start_0 = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    int n;
    n = 0;
    while (done_0 !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (done_0 !== 1'b1) fail_now({tag, " done timeout"});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " sk_in"}, sk_in_0, 0);
    chk({tag, " busy"}, busy_0, 0);
    chk({tag, " done"}, done_0, 0);
    chk({tag, " pass"}, pass_0, 0);
    chk({tag, " fail_count"}, fc_0, 0);
    chk({tag, " first_fail_vec"}, ffv_0, 0);
    chk({tag, " first_fail_valid"}, ffval_0, 0);
    chk({tag, " state"}, st_0, ST_IDLE);
  endtask

  initial begin : main
    int n;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    fork
      begin : drv1
        @(negedge clk);
        start_1 = 1'b1; start_cyc1 = cyc; exp_q1.push_back(mk(LAT1, 1'b0, 120, 8'h01, 1'b1));
        @(negedge clk);
        start_1 = 1'b0;
        n = 0;
        while (done_1 !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        if (done_1 !== 1'b1) fail_now("u1 done timeout");
      end
      begin : drv3
        int m;
        @(negedge clk);
        start_3 = 1'b1; start_cyc3 = cyc; exp_q3.push_back(mk(LAT3, 1'b1, 0, 0, 1'b0));
        @(negedge clk);
        start_3 = 1'b0;
        m = 0;
        while (done_3 !== 1'b1 && m < TMO) begin @(negedge clk); m++; end
        if (done_3 !== 1'b1) fail_now("u3 done timeout");
      end
      begin : drv0
        start0(0, mk(LAT1, 1'b1, 0, 0, 1'b0));
        wait_done0("u0 ideal");
        start0(1, mk(LAT1, 1'b0, 49, 8'h00, 1'b1));
        wait_done0("u0 stub F");
        start0(2, mk(LAT1, 1'b1, 0, 0, 1'b0));
        wait_done0("u0 stub 0");

        // Stray start around cycle 100 of a run must be ignored.
        start0(1, mk(LAT1, 1'b0, 49, 8'h00, 1'b1));
        repeat (98) @(negedge clk);
        start_0 = 1'b1;
        chk("u0 busy mid-run", busy_0, 1);
        @(negedge clk);
        start_0 = 1'b0;
        wait_done0("u0 stray start");

        // start held through DONE: ignored there, accepted in the first IDLE cycle.
        mode0 = 2;
        start_0 = 1'b1;
        @(negedge clk);
        chk("u0 start in DONE ignored", busy_0, 0);
        chk("u0 idle after DONE", st_0, ST_IDLE);
        start_cyc0 = cyc;
        exp_q0.push_back(mk(LAT1, 1'b1, 0, 0, 1'b0));
        @(negedge clk);
        start_0 = 1'b0;
        chk("u0 start in IDLE accepted", busy_0, 1);
        wait_done0("u0 restart");
      end
    join

    // Asynchronous reset mid-run discards the run.
    start0(1, mk(LAT1, 1'b0, 49, 8'h00, 1'b1));
    repeat (1998) @(negedge clk);
    chk("u0 busy before rst", busy_0, 1);
    chk("u0 first_fail_valid before rst", ffval_0, 1);
    #2 rst = 1'b1;
    #1 check_reset_vals("async rst");
    exp_q0.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    start0(0, mk(LAT1, 1'b1, 0, 0, 1'b0));
    wait_done0("u0 after rst");
    repeat (3) @(negedge clk);

    chk("u0 scoreboard drained", exp_q0.size(), 0);
    chk("u1 scoreboard drained", exp_q1.size(), 0);
    chk("u3 scoreboard drained", exp_q3.size(), 0);
    chk("u3 settle entries", entries3, 256);
    chk("u3 sk_in sequence/hold violations", viol3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
